// File: rtl/rope_shot_controller_pkg.sv
// Shared types and constants for the rope shot datapath and its bus interface.
package rope_pkg;

  localparam int COORD_W           = 11;
  localparam int ROPE_WIDTH        = 6;
  localparam int SCREEN_HEIGHT     = 480;
  localparam int DEFAULT_FLOOR_Y   = SCREEN_HEIGHT - 40;
  localparam int DEFAULT_CEILING_Y = 16;

  typedef enum logic [1:0] {
    IDLE,
    EXTEND,
    HOLD
  } rope_state_t;

endpackage

// File: rtl/rope_shot_controller_if.sv
// Bundles the player/frame inputs and the rope rectangle outputs of the
// rope shot controller. The controller sits on the slave side.
interface rope_shot_controller_if;
  import rope_pkg::*;

  logic               startOfFrame;
  logic               fireKey;
  logic [COORD_W-1:0] playerX;
  logic               ballHit;
  logic               pause;

  logic               ropeActive;
  logic [COORD_W-1:0] topLeftX;
  logic [COORD_W-1:0] topLeftY;
  logic [COORD_W-1:0] ropeHeight;
  logic               ropeHitBall;
  logic               shotDone;

  modport master (
    output startOfFrame, fireKey, playerX, ballHit, pause,
    input  ropeActive, topLeftX, topLeftY, ropeHeight, ropeHitBall, shotDone
  );

  modport slave (
    input  startOfFrame, fireKey, playerX, ballHit, pause,
    output ropeActive, topLeftX, topLeftY, ropeHeight, ropeHitBall, shotDone
  );

endinterface

// File: rtl/rope_shot_controller_key_edge_detect.sv
// Registered rising-edge detector for a key level; usable for any key input.
module key_edge_detect (
  input  logic clk,
  input  logic resetN,
  input  logic key,
  output logic rise
);

  logic keyD;

  // Remember last cycle's key level so a held key produces a single edge.
  always_ff @(posedge clk) begin
    if (!resetN) keyD <= 1'b0;
    else         keyD <= key;
  end

  assign rise = key & ~keyD;

endmodule

// File: rtl/rope_shot_controller.sv
// Rope shot sequencer: latches a fire request, launches the rope at the
// player, grows it once per frame, holds it at the ceiling and retracts it on
// timeout or ball collision. All outputs are registered.
module rope_shot_controller
  import rope_pkg::*;
#(
  parameter int FLOOR_Y         = DEFAULT_FLOOR_Y,
  parameter int CEILING_Y       = DEFAULT_CEILING_Y,
  parameter int ROPE_SPEED      = 8,
  parameter int HOLD_FRAMES     = 30,
  parameter int PLAYER_CENTER_X = 16
) (
  input logic                 clk,
  input logic                 resetN,
  rope_shot_controller_if.slave bus
);

  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  localparam logic [COORD_W-1:0] FLOOR_C    = COORD_W'(FLOOR_Y);
  localparam logic [COORD_W-1:0] CEIL_C     = COORD_W'(CEILING_Y);
  localparam logic [COORD_W-1:0] SPEED_C    = COORD_W'(ROPE_SPEED);
  localparam logic [COORD_W-1:0] STOP_C     = COORD_W'(CEILING_Y + ROPE_SPEED);
  localparam logic [COORD_W-1:0] X_OFFSET_C = COORD_W'(PLAYER_CENTER_X - ROPE_WIDTH / 2);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD_C = HOLD_W'(HOLD_FRAMES - 1);

  rope_state_t        state, stateNext;
  logic               firePending, pendingNext;
  logic [HOLD_W-1:0]  holdCnt, cntNext;
  logic [COORD_W-1:0] xReg, xNext;
  logic [COORD_W-1:0] yReg, yNext;
  logic [COORD_W-1:0] heightReg;
  logic               activeReg;
  logic               hitReg, hitNext;
  logic               doneReg, doneNext;
  logic               fireRise;
  logic               frameStep;

  key_edge_detect u_fireEdge (
    .clk    (clk),
    .resetN (resetN),
    .key    (bus.fireKey),
    .rise   (fireRise)
  );

  assign frameStep = bus.startOfFrame & ~bus.pause;

  // Next-state and next-output decisions; a collision always beats a growth
  // step, and fire edges only count while no rope is on screen.
  always_comb begin
    stateNext   = state;
    pendingNext = firePending;
    cntNext     = holdCnt;
    xNext       = xReg;
    yNext       = yReg;
    hitNext     = 1'b0;
    doneNext    = 1'b0;

    case (state)
      IDLE: begin
        if (frameStep && firePending) begin
          stateNext   = EXTEND;
          xNext       = bus.playerX + X_OFFSET_C;
          yNext       = FLOOR_C - SPEED_C;
          pendingNext = 1'b0;
        end else if (fireRise) begin
          pendingNext = 1'b1;
        end
      end
      EXTEND: begin
        if (bus.ballHit) begin
          stateNext = IDLE;
          yNext     = FLOOR_C;
          hitNext   = 1'b1;
          doneNext  = 1'b1;
        end else if (frameStep) begin
          if (yReg <= STOP_C) begin
            stateNext = HOLD;
            yNext     = CEIL_C;
            cntNext   = HOLD_LOAD_C;
          end else begin
            yNext = yReg - SPEED_C;
          end
        end
      end
      HOLD: begin
        if (bus.ballHit) begin
          stateNext = IDLE;
          yNext     = FLOOR_C;
          hitNext   = 1'b1;
          doneNext  = 1'b1;
        end else if (frameStep) begin
          if (holdCnt == '0) begin
            stateNext = IDLE;
            yNext     = FLOOR_C;
            doneNext  = 1'b1;
          end else begin
            cntNext = holdCnt - 1'b1;
          end
        end
      end
      default: begin
        stateNext = IDLE;
        yNext     = FLOOR_C;
      end
    endcase
  end

  // Register the state and every output so drawing logic sees stable values
  // for the whole frame; reset silently abandons any shot in flight.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state       <= IDLE;
      firePending <= 1'b0;
      holdCnt     <= '0;
      xReg        <= '0;
      yReg        <= FLOOR_C;
      heightReg   <= '0;
      activeReg   <= 1'b0;
      hitReg      <= 1'b0;
      doneReg     <= 1'b0;
    end else begin
      state       <= stateNext;
      firePending <= pendingNext;
      holdCnt     <= cntNext;
      xReg        <= xNext;
      yReg        <= yNext;
      heightReg   <= FLOOR_C - yNext;
      activeReg   <= (stateNext != IDLE);
      hitReg      <= hitNext;
      doneReg     <= doneNext;
    end
  end

  assign bus.ropeActive  = activeReg;
  assign bus.topLeftX    = xReg;
  assign bus.topLeftY    = yReg;
  assign bus.ropeHeight  = heightReg;
  assign bus.ropeHitBall = hitReg;
  assign bus.shotDone    = doneReg;

endmodule

// File: tb/tb_rope_shot_controller.sv
// Bench for rope_shot_controller: a directed vector table, hand-written
// multi-cycle sequences and a randomized run, all compared each cycle against
// a frame-counting reference model. Two instances run in lockstep, one with
// an 8-pixel step and one with a 7-pixel step.
module tb_rope_shot_controller;

  localparam int FLOOR = 440;
  localparam int CEIL  = 16;
  localparam int HOLD  = 30;
  localparam int XOFF  = 13;

  typedef struct {
    bit active;
    int grown;
    bit atCeil;
    int holdLeft;
    bit pending;
    bit keyPrev;
    int x;
    bit hit;
    bit done;
  } model_t;

  typedef struct {
    bit rstN;
    bit sof;
    bit fire;
    int px;
    bit hit;
    bit pz;
    bit expActive;
    int expX;
    int expY;
    int expH;
    bit expHit;
    bit expDone;
  } vec_t;

  logic clk = 1'b0;
  logic resetN;

  rope_shot_controller_if busA ();
  rope_shot_controller_if busB ();

  rope_shot_controller #(.ROPE_SPEED(8)) dutA (
    .clk    (clk),
    .resetN (resetN),
    .bus    (busA)
  );

  rope_shot_controller #(.ROPE_SPEED(7), .FLOOR_Y(440), .CEILING_Y(16)) dutB (
    .clk    (clk),
    .resetN (resetN),
    .bus    (busB)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  int     checkCount = 0;
  int     passCount  = 0;
  model_t mA;
  model_t mB;
  bit     curFire  = 1'b0;
  int     curPx    = 0;
  bit     curPause = 1'b0;
  vec_t   vecs[12];

  // Reference behaviour in terms of frames grown and frames left at the
  // ceiling; the rope top is derived from these counts when needed.
  function automatic model_t modelStep(input model_t m, input bit rstN, input bit sof,
                                       input bit fire, input int px, input bit hit,
                                       input bit pz, input int speed);
    model_t n;
    bit     rise;
    n = m;
    n.hit  = 1'b0;
    n.done = 1'b0;
    if (!rstN) begin
      n = '{default: 0};
      return n;
    end
    rise      = fire && !m.keyPrev;
    n.keyPrev = fire;
    if (!m.active) begin
      if (sof && !pz && m.pending) begin
        n.active  = 1'b1;
        n.grown   = 1;
        n.atCeil  = 1'b0;
        n.x       = (px + XOFF) % 2048;
        n.pending = 1'b0;
      end else if (rise) begin
        n.pending = 1'b1;
      end
    end else if (hit) begin
      n.active = 1'b0;
      n.hit    = 1'b1;
      n.done   = 1'b1;
    end else if (sof && !pz) begin
      if (!m.atCeil) begin
        if (FLOOR - speed * (m.grown + 1) <= CEIL) begin
          n.atCeil   = 1'b1;
          n.holdLeft = HOLD;
        end else begin
          n.grown = m.grown + 1;
        end
      end else begin
        n.holdLeft = m.holdLeft - 1;
        if (n.holdLeft == 0) begin
          n.active = 1'b0;
          n.done   = 1'b1;
        end
      end
    end
    return n;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic checkModel(input string tag, input model_t m, input int speed,
                            input int act, input int x, input int y, input int h,
                            input int hit, input int done);
    int ey;
    ey = m.active ? (m.atCeil ? CEIL : FLOOR - speed * m.grown) : FLOOR;
    checkOutput({tag, ".ropeActive"},  act,  int'(m.active));
    checkOutput({tag, ".topLeftX"},    x,    m.x);
    checkOutput({tag, ".topLeftY"},    y,    ey);
    checkOutput({tag, ".ropeHeight"},  h,    FLOOR - ey);
    checkOutput({tag, ".ropeHitBall"}, hit,  int'(m.hit));
    checkOutput({tag, ".shotDone"},    done, int'(m.done));
  endtask

  // Drive one clock of inputs to both instances, advance the model across the
  // edge and compare both instances shortly after it.
  task automatic applyStimulus(input bit rstN, input bit sof, input bit fire,
                               input int px, input bit hit, input bit pz);
    resetN            = rstN;
    busA.startOfFrame = sof;
    busA.fireKey      = fire;
    busA.playerX      = 11'(px);
    busA.ballHit      = hit;
    busA.pause        = pz;
    busB.startOfFrame = sof;
    busB.fireKey      = fire;
    busB.playerX      = 11'(px);
    busB.ballHit      = hit;
    busB.pause        = pz;
    @(posedge clk);
    mA = modelStep(mA, rstN, sof, fire, px, hit, pz, 8);
    mB = modelStep(mB, rstN, sof, fire, px, hit, pz, 7);
    #1;
    checkModel("A", mA, 8, int'(busA.ropeActive), int'(busA.topLeftX), int'(busA.topLeftY),
               int'(busA.ropeHeight), int'(busA.ropeHitBall), int'(busA.shotDone));
    checkModel("B", mB, 7, int'(busB.ropeActive), int'(busB.topLeftX), int'(busB.topLeftY),
               int'(busB.ropeHeight), int'(busB.ropeHitBall), int'(busB.shotDone));
  endtask

  task automatic tick(input bit sof, input bit hit);
    applyStimulus(1'b1, sof, curFire, curPx, hit, curPause);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      tick(1'b1, 1'b0);
      repeat (3) tick(1'b0, 1'b0);
    end
  endtask

  task automatic pressFire();
    curFire = 1'b0;
    tick(1'b0, 1'b0);
    curFire = 1'b1;
    tick(1'b0, 1'b0);
  endtask

  task automatic doReset();
    curFire  = 1'b0;
    curPause = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, curPx, 1'b0, 1'b0);
  endtask

  initial begin
    mA = '{default: 0};
    mB = '{default: 0};

    // rstN sof fire px hit pz | active x y height hit done (step-8 instance)
    vecs[0]  = '{0, 0, 0, 100, 0, 0,  0,   0, 440,  0, 0, 0};
    vecs[1]  = '{1, 0, 1, 100, 0, 0,  0,   0, 440,  0, 0, 0};
    vecs[2]  = '{1, 1, 1, 100, 0, 0,  1, 113, 432,  8, 0, 0};
    vecs[3]  = '{1, 1, 1, 300, 0, 0,  1, 113, 424, 16, 0, 0};
    vecs[4]  = '{1, 0, 0, 300, 0, 0,  1, 113, 424, 16, 0, 0};
    vecs[5]  = '{1, 0, 0, 300, 1, 0,  0, 113, 440,  0, 1, 1};
    vecs[6]  = '{1, 0, 0, 300, 0, 0,  0, 113, 440,  0, 0, 0};
    vecs[7]  = '{1, 0, 0, 300, 1, 0,  0, 113, 440,  0, 0, 0};
    vecs[8]  = '{1, 0, 1, 100, 0, 0,  0, 113, 440,  0, 0, 0};
    vecs[9]  = '{1, 1, 1, 100, 0, 1,  0, 113, 440,  0, 0, 0};
    vecs[10] = '{1, 1, 1, 100, 0, 0,  1, 113, 432,  8, 0, 0};
    vecs[11] = '{1, 1, 1, 100, 1, 0,  0, 113, 440,  0, 1, 1};

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].sof, vecs[i].fire, vecs[i].px, vecs[i].hit, vecs[i].pz);
      checkOutput($sformatf("vec%0d.ropeActive", i),  int'(busA.ropeActive),  int'(vecs[i].expActive));
      checkOutput($sformatf("vec%0d.topLeftX", i),    int'(busA.topLeftX),    vecs[i].expX);
      checkOutput($sformatf("vec%0d.topLeftY", i),    int'(busA.topLeftY),    vecs[i].expY);
      checkOutput($sformatf("vec%0d.ropeHeight", i),  int'(busA.ropeHeight),  vecs[i].expH);
      checkOutput($sformatf("vec%0d.ropeHitBall", i), int'(busA.ropeHitBall), int'(vecs[i].expHit));
      checkOutput($sformatf("vec%0d.shotDone", i),    int'(busA.shotDone),    int'(vecs[i].expDone));
    end

    // Full shot with the key held down the whole time.
    doReset();
    curPx = 100;
    pressFire();
    frames(1);
    checkOutput("launch.topLeftX", int'(busA.topLeftX), 113);
    checkOutput("launch.topLeftY", int'(busA.topLeftY), 432);
    checkOutput("launch.height", int'(busA.ropeHeight), 8);
    checkOutput("launchB.topLeftY", int'(busB.topLeftY), 433);
    frames(52);
    checkOutput("ceilA.topLeftY", int'(busA.topLeftY), 16);
    checkOutput("ceilA.active", int'(busA.ropeActive), 1);
    frames(7);
    checkOutput("preClampB.topLeftY", int'(busB.topLeftY), 20);
    frames(1);
    checkOutput("clampB.topLeftY", int'(busB.topLeftY), 16);
    frames(21);
    checkOutput("holdA.active", int'(busA.ropeActive), 1);
    tick(1'b1, 1'b0);
    checkOutput("timeoutA.shotDone", int'(busA.shotDone), 1);
    checkOutput("timeoutA.active", int'(busA.ropeActive), 0);
    checkOutput("timeoutA.topLeftY", int'(busA.topLeftY), 440);
    repeat (3) tick(1'b0, 1'b0);
    frames(10);
    checkOutput("heldKeyA.active", int'(busA.ropeActive), 0);
    checkOutput("heldKeyB.active", int'(busB.ropeActive), 0);

    // Collision during extension.
    pressFire();
    frames(10);
    checkOutput("midA.topLeftY", int'(busA.topLeftY), 360);
    tick(1'b0, 1'b1);
    checkOutput("hitA.ropeHitBall", int'(busA.ropeHitBall), 1);
    checkOutput("hitA.shotDone", int'(busA.shotDone), 1);
    checkOutput("hitA.active", int'(busA.ropeActive), 0);
    checkOutput("hitA.height", int'(busA.ropeHeight), 0);
    tick(1'b0, 1'b0);
    checkOutput("hitA.pulseEnd", int'(busA.ropeHitBall), 0);

    // Fire during extension is ignored; collision beats a same-cycle frame.
    pressFire();
    frames(3);
    pressFire();
    frames(2);
    checkOutput("tieA.before", int'(busA.topLeftY), 400);
    tick(1'b1, 1'b1);
    checkOutput("tieA.topLeftY", int'(busA.topLeftY), 440);
    checkOutput("tieA.ropeHitBall", int'(busA.ropeHitBall), 1);
    frames(3);
    checkOutput("noRelaunchA.active", int'(busA.ropeActive), 0);

    // Pause freezes growth but not collisions.
    pressFire();
    frames(5);
    checkOutput("pauseA.start", int'(busA.topLeftY), 400);
    curPause = 1'b1;
    frames(5);
    checkOutput("pauseA.frozen", int'(busA.topLeftY), 400);
    tick(1'b0, 1'b1);
    checkOutput("pauseA.ropeHitBall", int'(busA.ropeHitBall), 1);
    checkOutput("pauseA.shotDone", int'(busA.shotDone), 1);
    curPause = 1'b0;
    tick(1'b0, 1'b0);

    // Reset while holding at the ceiling, then a fresh shot.
    pressFire();
    frames(55);
    checkOutput("preResetA.topLeftY", int'(busA.topLeftY), 16);
    doReset();
    checkOutput("resetA.active", int'(busA.ropeActive), 0);
    checkOutput("resetA.topLeftX", int'(busA.topLeftX), 0);
    checkOutput("resetA.topLeftY", int'(busA.topLeftY), 440);
    checkOutput("resetA.shotDone", int'(busA.shotDone), 0);
    curPx = 200;
    pressFire();
    frames(1);
    checkOutput("refireA.topLeftX", int'(busA.topLeftX), 213);
    checkOutput("refireA.topLeftY", int'(busA.topLeftY), 432);

    // Randomized traffic against the model.
    doReset();
    repeat (4000) begin
      if ($urandom_range(0, 9) == 0) curFire = ~curFire;
      if ($urandom_range(0, 49) == 0) curPx = int'($urandom_range(0, 2047));
      applyStimulus($urandom_range(0, 599) != 0, $urandom_range(0, 5) == 0, curFire, curPx,
                    $urandom_range(0, 299) == 0, $urandom_range(0, 15) == 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/rope_shot_controller.md
# rope_shot_controller

Sequences the player's rope shot: latches a fire request, launches the rope at the player's position, grows it upward once per video frame, holds it at the ceiling, and retracts it on ceiling timeout or ball collision. It sits between the player/keyboard logic and the rope bitmap drawing path. It supplies the rope rectangle's top-left corner, height and active flag. It also supplies hit/done pulses to the ball-split and scoring logic.

## Interface
- FLOOR_Y, 440, y of rope base (player feet); rope bottom edge
- CEILING_Y, 16, minimum topLeftY; rope stops here
- ROPE_SPEED, 8, pixels of growth per frame (1..63)
- HOLD_FRAMES, 30, frames rope stays at ceiling before retracting
- PLAYER_CENTER_X, 16, offset from playerX to player centre

- clk  in  1  system clock
- resetN  in  1  active-low reset; one clock; reset is synchronous and active-low
- startOfFrame  in  1  one-cycle pulse per video frame
- fireKey  in  1  fire key level
- playerX  in  11  player top-left x
- ballHit  in  1  rope/ball collision, level or pulse
- pause  in  1  freezes motion and launch
- ropeActive  out  1  rope rectangle valid for drawing
- topLeftX  out  11  rope rectangle x
- topLeftY  out  11  rope rectangle top y
- ropeHeight  out  11  FLOOR_Y - topLeftY; 0 when idle
- ropeHitBall  out  1  one-cycle pulse on accepted collision
- shotDone  out  1  one-cycle pulse when rope retracts for any reason

## Operation
- Fire detect: fireKey is registered. The edge is fireKey & !fireKey_d.
  - An edge in IDLE sets firePending.
  - Edges in EXTEND/HOLD are ignored. One rope exists at a time. Holding the key never re-fires.
- States: IDLE, EXTEND, HOLD.
- IDLE → EXTEND on startOfFrame & firePending & !pause.
  - topLeftX ← playerX + PLAYER_CENTER_X - 3, latched once. The rope does not follow the player.
  - topLeftY ← FLOOR_Y - ROPE_SPEED.
  - firePending cleared.
- EXTEND, on startOfFrame & !pause:
  - If topLeftY <= CEILING_Y + ROPE_SPEED, then topLeftY ← CEILING_Y, holdCnt ← HOLD_FRAMES-1, and the state goes to HOLD.
  - Otherwise topLeftY ← topLeftY - ROPE_SPEED.
  - The comparison form avoids unsigned underflow.
- HOLD, on startOfFrame & !pause:
  - If holdCnt == 0, go to IDLE and pulse shotDone.
  - Otherwise decrement holdCnt.
- ballHit while in EXTEND or HOLD:
  - The state goes to IDLE on the next edge.
  - ropeHitBall and shotDone pulse together.
  - ballHit is accepted even when pause=1.
  - ballHit in IDLE is ignored.
- ballHit and startOfFrame in the same cycle: ballHit wins. No growth step occurs.
- Entering IDLE: ropeActive=0, topLeftY=FLOOR_Y, ropeHeight=0. topLeftX keeps its last value.
- ropeActive=1 exactly in EXTEND/HOLD.
- ropeHeight = FLOOR_Y - topLeftY. It is an 11-bit unsigned value, registered alongside topLeftY.
- A fire edge in the same cycle as the return to IDLE is dropped. It is not carried over.

## Timing
- All outputs are registered.
- Reset values:
  - State IDLE, firePending=0, fireKey_d=0.
  - ropeActive=0, topLeftX=0, topLeftY=FLOOR_Y, ropeHeight=0, pulses=0.
- resetN low in any state aborts the shot. No shotDone pulse is issued.
- Latency:
  - A fire edge registered in cycle t sets firePending at t+1.
  - Launch happens on the first startOfFrame cycle after that. Outputs change one clock after that pulse.
- Growth: one step per startOfFrame, visible one clock later. This is stable for the whole frame.
- Full extension from launch to HOLD: ceil((FLOOR_Y-CEILING_Y)/ROPE_SPEED) frames.
- HOLD lasts exactly HOLD_FRAMES frame pulses.
- Collision response: 1 clock.

## Structure
- Package rope_pkg holds:
  - The state enum typedef rope_state_t.
  - COORD_W=11, ROPE_WIDTH=6.
  - Default FLOOR_Y, CEILING_Y and screen height 480.
- The natural sub-module is key_edge_detect. It is a registered rising-edge detector, reused for other keys.
- holdCnt width is $clog2(HOLD_FRAMES+1).

## Test plan
- Full shot: reset, playerX=100, then fire, then frames.
  - Launch: topLeftX=113, topLeftY=432, height=8.
  - After 53 frames: topLeftY=16, state HOLD.
  - 30 frames later: shotDone pulse, ropeActive=0, topLeftY=440.
- Collision mid-extension: fire, 10 frames (topLeftY=360), then ballHit pulse.
  - Next clock: ropeHitBall=1, shotDone=1, ropeActive=0, height=0.
- Re-fire suppression and tie-break:
  - Hold fireKey high across a complete shot. No second launch occurs.
  - Fire during EXTEND is ignored.
  - ballHit coincident with startOfFrame retracts with no growth step.
- Pause: pause=1 during EXTEND at topLeftY=400 for 5 frames.
  - topLeftY stays 400.
  - ballHit while paused still yields the hit pulses.
- Mid-operation reset:
  - resetN=0 for one clock during HOLD gives all reset values and no shotDone.
  - A fresh fire launches normally.
- Edge parameters: ROPE_SPEED=7, FLOOR_Y=440, CEILING_Y=16.
  - The last step clamps from 20 to 16.
  - HOLD is entered after 61 frames, with no underflow.
